// File: rtl/wave_display_multi.sv
// Multi-trace waveform renderer: master plus note traces drawn as joined segments
// inside a fixed raster window, with a fixed 3-cycle registered output.
module wave_display_multi #(
  parameter int unsigned NUM_CH       = 10,
  parameter int unsigned SAMPLE_W     = 8,
  parameter int unsigned X_START      = 256,
  parameter int unsigned COLS_LOG2    = 8,
  parameter int unsigned STEEP_THRESH = 20
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [NUM_CH*SAMPLE_W-1:0]   rd_data,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         dot_mode,
  output logic [COLS_LOG2:0]           read_address,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  localparam int unsigned AW    = COLS_LOG2 + 1;
  localparam int unsigned X_END = X_START + (1 << (COLS_LOG2 + 1));
  localparam int unsigned Y_LIM = 1 << SAMPLE_W;

  function automatic logic [23:0] palette(input int unsigned idx);
    case (idx % 8)
      0:       palette = 24'hFFFFFF;
      1:       palette = 24'h5A3278;
      2:       palette = 24'h852064;
      3:       palette = 24'h2842A0;
      4:       palette = 24'h33755E;
      5:       palette = 24'h964B23;
      6:       palette = 24'hB0B030;
      default: palette = 24'h30A0B0;
    endcase
  endfunction

  function automatic logic [23:0] scale34(input logic [23:0] p);
    scale34 = '0;
    for (int unsigned i = 0; i < 3; i++)
      scale34[i*8 +: 8] = (p[i*8 +: 8] >> 1) + (p[i*8 +: 8] >> 2);
  endfunction

  logic                 in_win;
  logic [COLS_LOG2-1:0] col;

  always_comb begin
    col          = COLS_LOG2'((x - 11'(X_START)) >> 1);
    in_win       = (32'(x) >= X_START) && (32'(x) < X_END) && (32'(y >> 1) < Y_LIM);
    read_address = in_win ? {read_index, col} : '0;
  end

  logic [AW-1:0]       addr_d1, s1_addr;
  logic [SAMPLE_W-1:0] ys_d1, ys_d2;
  logic                valid_d1, valid_d2, win_d1, win_d2, dot_d1, dot_d2;
  logic [NUM_CH-1:0]   en_d1, en_d2;
  logic [SAMPLE_W-1:0] prev_s [NUM_CH];
  logic [SAMPLE_W-1:0] cur_s  [NUM_CH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_d1  <= '0;
      ys_d1    <= '0;
      valid_d1 <= 1'b0;
      win_d1   <= 1'b0;
      en_d1    <= '0;
      dot_d1   <= 1'b0;
    end else begin
      addr_d1  <= read_address;
      ys_d1    <= y[SAMPLE_W:1];
      valid_d1 <= valid;
      win_d1   <= in_win;
      en_d1    <= ch_enable;
      dot_d1   <= dot_mode;
    end
  end

  // win_d2 is win_d1 one cycle later, so win_d1 & !win_d2 marks a line's first column
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_addr  <= '0;
      ys_d2    <= '0;
      valid_d2 <= 1'b0;
      win_d2   <= 1'b0;
      en_d2    <= '0;
      dot_d2   <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        prev_s[c] <= '0;
        cur_s[c]  <= '0;
      end
    end else begin
      ys_d2    <= ys_d1;
      valid_d2 <= valid_d1;
      win_d2   <= win_d1;
      en_d2    <= en_d1;
      dot_d2   <= dot_d1;
      if (win_d1) begin
        s1_addr <= addr_d1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          cur_s[c] <= rd_data[c*SAMPLE_W +: SAMPLE_W];
          if (!win_d2)
            prev_s[c] <= rd_data[c*SAMPLE_W +: SAMPLE_W];
          else if (addr_d1 != s1_addr)
            prev_s[c] <= cur_s[c];
        end
      end
    end
  end

  logic [NUM_CH-1:0] hit_v;
  logic [23:0]       rgb_v [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SAMPLE_W-1:0] pv, cv, lo, hi, lo_m, hi_p, spread;
    logic                core, halo, steep, inner;

    assign pv     = prev_s[c];
    assign cv     = cur_s[c];
    assign lo     = (pv < cv) ? pv : cv;
    assign hi     = (pv < cv) ? cv : pv;
    assign lo_m   = (lo == '0) ? '0 : lo - 1'b1;
    assign hi_p   = (hi == '1) ? '1 : hi + 1'b1;
    assign spread = hi - lo;
    assign core   = en_d2[c] && (dot_d2 ? (ys_d2 == cv) : (ys_d2 >= lo && ys_d2 <= hi));
    assign halo   = en_d2[c] && !core && (ys_d2 >= lo_m) && (ys_d2 <= hi_p);
    assign steep  = !dot_d2 && (32'(spread) > STEEP_THRESH);
    assign inner  = core && steep && (ys_d2 != pv) && (ys_d2 != cv);

    assign hit_v[c] = core || halo;
    assign rgb_v[c] = inner ? scale34(palette(c)) :
                      core  ? palette(c) :
                              (palette(c) >> 1) & 24'h7F7F7F;
  end

  logic [23:0] pix_rgb;
  logic        found;

  always_comb begin
    pix_rgb = '0;
    found   = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!found && hit_v[c]) begin
        found   = 1'b1;
        pix_rgb = rgb_v[c];
      end
    end
    if (!win_d2)
      pix_rgb = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      valid_pixel <= 1'b0;
    end else begin
      r           <= pix_rgb[23:16];
      g           <= pix_rgb[15:8];
      b           <= pix_rgb[7:0];
      valid_pixel <= valid_d2;
    end
  end

endmodule

// File: tb/tb_wave_display_multi.sv
// Scoreboard bench for wave_display_multi: directed pixels push hand-computed
// colours, a negedge monitor pops and compares whenever valid_pixel is high.
module tb_wave_display_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [79:0] rd_data = '0;
  logic [9:0]  ch_enable;
  logic        dot_mode;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;

  wave_display_multi #(
    .NUM_CH(10), .SAMPLE_W(8), .X_START(256), .COLS_LOG2(8), .STEEP_THRESH(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .valid(valid),
    .read_index(read_index), .rd_data(rd_data), .ch_enable(ch_enable),
    .dot_mode(dot_mode), .read_address(read_address), .valid_pixel(valid_pixel),
    .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  logic [79:0] mem [512];
  always @(posedge clk) rd_data <= mem[read_address];

  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;
  logic [23:0] exp_q [$];
  string       nm_q  [$];
  logic [23:0] e_rgb;
  string       e_nm;

  always @(negedge clk) begin
    if (mon_en && reset_n && valid_pixel) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pixel got=%06h want=none", {r, g, b});
      end else begin
        e_rgb = exp_q.pop_front();
        e_nm  = nm_q.pop_front();
        if ({r, g, b} !== e_rgb) begin
          bad++;
          $display("FAIL %s got=%06h want=%06h", e_nm, {r, g, b}, e_rgb);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic pix(input int xi, input int yi, input bit v, input bit ri,
                     input logic [9:0] en, input bit dm, input logic [23:0] e, input string nm);
    @(posedge clk); #1;
    x = xi[10:0]; y = yi[9:0]; valid = v; read_index = ri; ch_enable = en; dot_mode = dm;
    if (v) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
  endtask

  task automatic addr_chk(input int xi, input int yi, input bit ri, input logic [8:0] want,
                          input string nm);
    @(posedge clk); #1;
    x = xi[10:0]; y = yi[9:0]; valid = 1'b0; read_index = ri;
    #1;
    check(nm, 32'(read_address), 32'(want));
  endtask

  task automatic set_smp(input int a, input int c, input logic [7:0] v);
    mem[a][c*8 +: 8] = v;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    set_smp(0, 0, 8'd40);  set_smp(0, 1, 8'd10);  set_smp(0, 4, 8'd30);
    set_smp(1, 0, 8'd50);  set_smp(1, 1, 8'd100);
    set_smp(10, 2, 8'd5);  set_smp(10, 3, 8'd250);
    set_smp(11, 2, 8'd0);  set_smp(11, 3, 8'd255);
    set_smp(255, 4, 8'd200);

    reset_n = 1'b0; x = '0; y = '0; valid = 1'b0; read_index = 1'b0;
    ch_enable = '0; dot_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {7'd0, valid_pixel, r, g, b}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    addr_chk(255, 0,   1'b1, 9'h000, "addr_x255");
    addr_chk(256, 0,   1'b1, 9'h100, "addr_x256");
    addr_chk(257, 0,   1'b1, 9'h100, "addr_x257");
    addr_chk(767, 0,   1'b1, 9'h1FF, "addr_x767");
    addr_chk(768, 0,   1'b1, 9'h000, "addr_x768");
    addr_chk(300, 0,   1'b1, 9'h116, "addr_x300");
    addr_chk(258, 510, 1'b1, 9'h101, "addr_y510");
    addr_chk(258, 512, 1'b1, 9'h000, "addr_y512");
    addr_chk(260, 0,   1'b0, 9'h002, "addr_ri0");

    // segment, halo, steep shading and priority on columns 0/1
    pix(100, 0, 1'b0, 1'b0, 10'h000, 1'b0, 24'h0, "sep");
    pix(256, 80,  1'b1, 1'b0, 10'h003, 1'b0, 24'hFFFFFF, "col0_ch0");
    pix(257, 20,  1'b1, 1'b0, 10'h002, 1'b0, 24'h5A3278, "col0_ch1");
    pix(258, 90,  1'b1, 1'b0, 10'h003, 1'b0, 24'hFFFFFF, "seg_core");
    pix(259, 102, 1'b1, 1'b0, 10'h003, 1'b0, 24'h7F7F7F, "seg_halo");
    pix(259, 104, 1'b1, 1'b0, 10'h001, 1'b0, 24'h000000, "seg_black");
    pix(259, 100, 1'b1, 1'b0, 10'h002, 1'b0, 24'h43255A, "steep_inner");
    pix(259, 100, 1'b1, 1'b0, 10'h003, 1'b0, 24'hFFFFFF, "prio_ch0");
    pix(259, 101, 1'b1, 1'b0, 10'h002, 1'b0, 24'h43255A, "steep_inner_odd");
    pix(259, 20,  1'b1, 1'b0, 10'h002, 1'b0, 24'h5A3278, "steep_end");
    pix(259, 18,  1'b1, 1'b0, 10'h002, 1'b0, 24'h2D193C, "steep_halo");
    pix(259, 100, 1'b1, 1'b0, 10'h000, 1'b0, 24'h000000, "all_off");
    pix(768, 90,  1'b1, 1'b0, 10'h003, 1'b0, 24'h000000, "out_x");
    pix(258, 512, 1'b1, 1'b0, 10'h003, 1'b0, 24'h000000, "out_y");

    // dot mode and saturation on columns 10/11
    pix(276, 0,   1'b1, 1'b0, 10'h004, 1'b1, 24'h000000, "dot_col10");
    pix(278, 0,   1'b1, 1'b0, 10'h004, 1'b1, 24'h852064, "dot_core");
    pix(279, 6,   1'b1, 1'b0, 10'h004, 1'b1, 24'h421032, "dot_halo");
    pix(279, 14,  1'b1, 1'b0, 10'h004, 1'b1, 24'h000000, "dot_none");
    pix(279, 6,   1'b1, 1'b0, 10'h004, 1'b0, 24'h852064, "line_core");
    pix(279, 510, 1'b1, 1'b0, 10'h004, 1'b0, 24'h000000, "no_wrap_lo");
    pix(279, 510, 1'b1, 1'b0, 10'h008, 1'b0, 24'h2842A0, "sat_hi_core");
    pix(279, 0,   1'b1, 1'b0, 10'h008, 1'b0, 24'h000000, "no_wrap_hi");
    pix(279, 498, 1'b1, 1'b0, 10'h008, 1'b0, 24'h142150, "sat_halo");
    pix(279, 0,   1'b1, 1'b0, 10'h00C, 1'b0, 24'h852064, "prio_ch2");

    // line start: previous line ends at 200, new line starts at 30
    pix(200, 0,   1'b0, 1'b0, 10'h010, 1'b0, 24'h0, "sep");
    pix(766, 400, 1'b1, 1'b0, 10'h010, 1'b0, 24'h33755E, "last_col");
    pix(768, 0,   1'b0, 1'b0, 10'h010, 1'b0, 24'h0, "sep");
    pix(256, 60,  1'b1, 1'b0, 10'h010, 1'b0, 24'h33755E, "first_core");
    pix(257, 58,  1'b1, 1'b0, 10'h010, 1'b0, 24'h193A2F, "first_halo_lo");
    pix(257, 62,  1'b1, 1'b0, 10'h010, 1'b0, 24'h193A2F, "first_halo_hi");
    pix(257, 64,  1'b1, 1'b0, 10'h010, 1'b0, 24'h000000, "first_edge");
    pix(257, 200, 1'b1, 1'b0, 10'h010, 1'b0, 24'h000000, "no_streak");
    pix(100, 0,   1'b0, 1'b0, 10'h000, 1'b0, 24'h0, "sep");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-line, then 3 cycles of flush
    mon_en = 1'b0;
    @(posedge clk); #1;
    x = 11'd256; y = 10'd80; valid = 1'b1; read_index = 1'b0; ch_enable = 10'h003; dot_mode = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset", {7'd0, valid_pixel, r, g, b}, {7'd0, 1'b1, 24'hFFFFFF});
    #2 reset_n = 1'b0;
    #1 check("async_clear", {7'd0, valid_pixel, r, g, b}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("rel_cycle0", 32'(valid_pixel), 32'd0);
    for (int k = 1; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rel_cycle%0d", k), 32'(valid_pixel), 32'd0);
    end
    @(posedge clk); #1;
    check("rel_cycle3", {7'd0, valid_pixel, r, g, b}, {7'd0, 1'b1, 24'hFFFFFF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
